// File: rtl/uart_frame_decoder.sv
// Byte-stream servo command decoder: 3-byte big-endian pulse width + terminator, clamped, ACK/NAK reply.
// Define FRAME_TIMEOUT_EN to compile in the inter-byte timeout that abandons stalled frames.
module uart_frame_decoder #(
  parameter logic [7:0]  TERMINATOR     = 8'h0A,
  parameter int unsigned PW_MIN         = 27000,
  parameter int unsigned PW_MAX         = 54000,
  parameter int unsigned PW_DEFAULT     = 40500,
  parameter int unsigned TIMEOUT_CYCLES = 2_700_000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        reset_uart,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic [23:0] pwm_width,
  output logic        pwm_update,
  output logic        frame_error,
  output logic [7:0]  frame_cnt,
  output logic        ack_valid,
  output logic [7:0]  ack_data,
  input  logic        ack_busy
);
  typedef enum logic [2:0] {RX_B0, RX_B1, RX_B2, RX_TERM, DISCARD} state_e;

  localparam logic [23:0] PW_MIN_W     = 24'(PW_MIN);
  localparam logic [23:0] PW_MAX_W     = 24'(PW_MAX);
  localparam logic [23:0] PW_DEFAULT_W = 24'(PW_DEFAULT);

  state_e      state_q;
  logic [23:0] shift_q;
  logic [23:0] pw_q;
  logic        pw_upd_q;
  logic        err_q;
  logic [7:0]  cnt_q;
  logic        ack_valid_q;
  logic [7:0]  ack_data_q;

  logic        is_term;
  logic        is_data;
  logic        timeout;
  logic [23:0] pw_clamp_d;

  assign is_term = uart_rx_valid && (uart_rx_data == TERMINATOR);
  assign is_data = uart_rx_valid && (uart_rx_data != TERMINATOR);

  always_comb begin
    pw_clamp_d = shift_q;
    if (shift_q < PW_MIN_W)      pw_clamp_d = PW_MIN_W;
    else if (shift_q > PW_MAX_W) pw_clamp_d = PW_MAX_W;
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_run;

  // Only a partially received (or discarded) frame can stall; RX_B0 is idle by definition.
  assign tmo_run = (state_q != RX_B0);
  assign timeout = tmo_run && !uart_rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset_uart) begin
    if (reset_uart)                               tmo_q <= '0;
    else if (uart_rx_valid || !tmo_run || timeout) tmo_q <= '0;
    else                                          tmo_q <= tmo_q + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset_uart) begin
    if (reset_uart) begin
      state_q     <= RX_B0;
      shift_q     <= '0;
      pw_q        <= PW_DEFAULT_W;
      pw_upd_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ack_valid_q <= 1'b0;
      ack_data_q  <= '0;
    end else begin
      pw_upd_q <= 1'b0;
      err_q    <= 1'b0;
      // A reply queued below in the same cycle overrides this consume.
      if (ack_valid_q && !ack_busy) ack_valid_q <= 1'b0;

      if (timeout) begin
        err_q       <= 1'b1;
        ack_valid_q <= 1'b1;
        ack_data_q  <= NAK_BYTE;
        shift_q     <= '0;
        state_q     <= RX_B0;
      end else begin
        case (state_q)
          RX_B0, RX_B1, RX_B2: begin
            if (is_term) begin
              err_q       <= 1'b1;
              ack_valid_q <= 1'b1;
              ack_data_q  <= NAK_BYTE;
              shift_q     <= '0;
              state_q     <= RX_B0;
            end else if (is_data) begin
              if (state_q == RX_B0) begin
                shift_q[23:16] <= uart_rx_data;
                state_q        <= RX_B1;
              end else if (state_q == RX_B1) begin
                shift_q[15:8] <= uart_rx_data;
                state_q       <= RX_B2;
              end else begin
                shift_q[7:0] <= uart_rx_data;
                state_q      <= RX_TERM;
              end
            end
          end
          RX_TERM: begin
            if (is_term) begin
              pw_q        <= pw_clamp_d;
              pw_upd_q    <= 1'b1;
              cnt_q       <= cnt_q + 8'd1;
              ack_valid_q <= 1'b1;
              ack_data_q  <= ACK_BYTE;
              state_q     <= RX_B0;
            end else if (is_data) begin
              err_q       <= 1'b1;
              ack_valid_q <= 1'b1;
              ack_data_q  <= NAK_BYTE;
              shift_q     <= '0;
              state_q     <= DISCARD;
            end
          end
          DISCARD: begin
            if (is_term) state_q <= RX_B0;
          end
          default: state_q <= RX_B0;
        endcase
      end
    end
  end

  assign pwm_width   = pw_q;
  assign pwm_update  = pw_upd_q;
  assign frame_error = err_q;
  assign frame_cnt   = cnt_q;
  assign ack_valid   = ack_valid_q;
  assign ack_data    = ack_data_q;
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Randomised and directed bench for uart_frame_decoder against a frame-level reference model.
module tb_uart_frame_decoder;
  localparam logic [7:0] TERM  = 8'h0A;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  localparam int         TMO   = 40;
  localparam int         PWMIN = 27000;
  localparam int         PWMAX = 54000;

  logic        clk = 1'b0;
  logic        reset_uart = 1'b1;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        ack_busy = 1'b0;
  logic [23:0] pwm_width;
  logic        pwm_update;
  logic        frame_error;
  logic [7:0]  frame_cnt;
  logic        ack_valid;
  logic [7:0]  ack_data;

  int checks = 0;
  int errors = 0;

  uart_frame_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_uart(reset_uart), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .pwm_width(pwm_width), .pwm_update(pwm_update),
    .frame_error(frame_error), .frame_cnt(frame_cnt), .ack_valid(ack_valid),
    .ack_data(ack_data), .ack_busy(ack_busy)
  );

  always #5 clk = ~clk;

  // Reference model: the bytes of the frame collected so far, plus a discard flag.
  logic [7:0]  frm[$];
  bit          mdl_discard;
  int          idle;
  int          exp_width;
  bit          exp_update, exp_error, exp_ack_valid;
  logic [7:0]  exp_cnt, exp_ack_data;

  task automatic model_reset();
    frm.delete();
    mdl_discard = 0; idle = 0;
    exp_width = 40500; exp_update = 0; exp_error = 0;
    exp_cnt = 0; exp_ack_valid = 0; exp_ack_data = 0;
  endtask

  task automatic reject();
    exp_error = 1; exp_ack_valid = 1; exp_ack_data = NAK;
  endtask

  // Drive one clock cycle of inputs (called at a negedge), advance the model, land on the next negedge.
  task automatic step(input bit v, input logic [7:0] d, input bit busy);
    int val;
    uart_rx_valid = v; uart_rx_data = d; ack_busy = busy;
    exp_update = 0; exp_error = 0;
    if (exp_ack_valid && !busy) exp_ack_valid = 0;
    if (v) begin
      idle = 0;
      if (mdl_discard) begin
        if (d == TERM) mdl_discard = 0;
      end else if (d == TERM) begin
        if (frm.size() == 3) begin
          val = frm[0] * 65536 + frm[1] * 256 + frm[2];
          exp_width = (val < PWMIN) ? PWMIN : (val > PWMAX) ? PWMAX : val;
          exp_update = 1; exp_cnt = exp_cnt + 8'd1;
          exp_ack_valid = 1; exp_ack_data = ACK;
        end else begin
          reject();
        end
        frm.delete();
      end else if (frm.size() == 3) begin
        reject(); mdl_discard = 1; frm.delete();
      end else begin
        frm.push_back(d);
      end
    end else if (frm.size() > 0 || mdl_discard) begin
`ifdef FRAME_TIMEOUT_EN
      idle++;
      if (idle == TMO) begin
        reject(); frm.delete(); mdl_discard = 0; idle = 0;
      end
`endif
    end
    @(negedge clk);
    uart_rx_valid = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (pwm_width !== 24'd40500) begin errors++; $display("FAIL reset_width got %0d exp 40500", pwm_width); end
    checks++; if (pwm_update !== 1'b0) begin errors++; $display("FAIL reset_update got %b exp 0", pwm_update); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", frame_error); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", frame_cnt); end
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL reset_ack_valid got %b exp 0", ack_valid); end
    checks++; if (ack_data !== 8'h00) begin errors++; $display("FAIL reset_ack_data got %h exp 00", ack_data); end
    reset_uart = 1'b0;
    model_reset();
    $display("reset: width=%0d cnt=%0d ack_valid=%b", pwm_width, frame_cnt, ack_valid);
  endtask

  task automatic test_directed();
    logic [7:0] seq[] = '{8'h00, 8'h9E, 8'h34, 8'h0A, 8'h14, 8'h00, 8'h00, 8'h0A,
                          8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h9E, 8'h0A,
                          8'h00, 8'hD2, 8'hF0, 8'h0A, 8'h00, 8'h9E, 8'h34, 8'h55, 8'hAA, 8'h0A,
                          8'h00, 8'h69, 8'h78, 8'h0A};
    int upd_seen = 0, err_seen = 0;
    foreach (seq[i]) begin
      step(1, seq[i], 0);
      upd_seen += int'(pwm_update); err_seen += int'(frame_error);
      checks++; if (pwm_width !== 24'(exp_width)) begin errors++; $display("FAIL dir_width byte %0d got %0d exp %0d", i, pwm_width, exp_width); end
      checks++; if (pwm_update !== exp_update) begin errors++; $display("FAIL dir_update byte %0d got %b exp %b", i, pwm_update, exp_update); end
      checks++; if (frame_error !== exp_error) begin errors++; $display("FAIL dir_error byte %0d got %b exp %b", i, frame_error, exp_error); end
      checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL dir_cnt byte %0d got %0d exp %0d", i, frame_cnt, exp_cnt); end
      checks++; if (ack_valid !== exp_ack_valid) begin errors++; $display("FAIL dir_ack_valid byte %0d got %b exp %b", i, ack_valid, exp_ack_valid); end
      if (exp_ack_valid) begin
        checks++; if (ack_data !== exp_ack_data) begin errors++; $display("FAIL dir_ack_data byte %0d got %h exp %h", i, ack_data, exp_ack_data); end
      end
      $display("directed byte %0d data=%h width=%0d upd=%b err=%b ack=%b/%h", i, seq[i], pwm_width, pwm_update, frame_error, ack_valid, ack_data);
    end
    checks++; if (upd_seen != 5) begin errors++; $display("FAIL dir_accept_count got %0d exp 5", upd_seen); end
    checks++; if (err_seen != 2) begin errors++; $display("FAIL dir_error_count got %0d exp 2", err_seen); end
    checks++; if (pwm_width !== 24'd27000) begin errors++; $display("FAIL dir_final_width got %0d exp 27000", pwm_width); end
  endtask

  task automatic test_timeout();
    int seen_at = 0;
    step(1, 8'h00, 0);
    for (int k = 1; k <= 3 * TMO; k++) begin
      step(0, 8'h00, 0);
      if (frame_error && seen_at == 0) seen_at = k;
      checks++; if (frame_error !== exp_error) begin errors++; $display("FAIL tmo_error idle %0d got %b exp %b", k, frame_error, exp_error); end
      checks++; if (ack_valid !== exp_ack_valid) begin errors++; $display("FAIL tmo_ack_valid idle %0d got %b exp %b", k, ack_valid, exp_ack_valid); end
      if (exp_ack_valid) begin
        checks++; if (ack_data !== exp_ack_data) begin errors++; $display("FAIL tmo_ack_data idle %0d got %h exp %h", k, ack_data, exp_ack_data); end
      end
    end
`ifdef FRAME_TIMEOUT_EN
    checks++; if (seen_at != TMO) begin errors++; $display("FAIL tmo_latency got %0d exp %0d", seen_at, TMO); end
`else
    checks++; if (seen_at != 0) begin errors++; $display("FAIL tmo_absent got %0d exp 0", seen_at); end
`endif
    $display("timeout: error seen at idle cycle %0d", seen_at);
    step(1, 8'h9E, 0); step(1, 8'h34, 0); step(1, TERM, 0);
    checks++; if (pwm_update !== exp_update) begin errors++; $display("FAIL tmo_resume_update got %b exp %b", pwm_update, exp_update); end
    checks++; if (frame_error !== exp_error) begin errors++; $display("FAIL tmo_resume_error got %b exp %b", frame_error, exp_error); end
    checks++; if (pwm_width !== 24'(exp_width)) begin errors++; $display("FAIL tmo_resume_width got %0d exp %0d", pwm_width, exp_width); end
    $display("timeout resume: width=%0d upd=%b err=%b", pwm_width, pwm_update, frame_error);
  endtask

  task automatic test_ack_hold();
    logic [7:0] seq[] = '{8'h00, 8'h0A, 8'h00, 8'h9E, 8'h34, 8'h0A, 8'h00, 8'hD2, 8'hF0, 8'h0A};
    logic [7:0] cnt0;
    step(0, 8'h00, 0); step(0, 8'h00, 0);
    cnt0 = frame_cnt;
    foreach (seq[i]) step(1, seq[i], 1);
    step(0, 8'h00, 1);
    checks++; if (ack_valid !== 1'b1) begin errors++; $display("FAIL hold_ack_valid got %b exp 1", ack_valid); end
    checks++; if (ack_data !== ACK) begin errors++; $display("FAIL hold_ack_data got %h exp 06", ack_data); end
    checks++; if (frame_cnt !== cnt0 + 8'd2) begin errors++; $display("FAIL hold_cnt got %0d exp %0d", frame_cnt, cnt0 + 8'd2); end
    checks++; if (pwm_width !== 24'd54000) begin errors++; $display("FAIL hold_width got %0d exp 54000", pwm_width); end
    step(0, 8'h00, 0);
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL hold_consume got %b exp 0", ack_valid); end
    $display("ack hold: cnt=%0d ack_valid=%b ack_data=%h", frame_cnt, ack_valid, ack_data);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      logic [7:0] b = (r < 22) ? TERM : (r < 35) ? 8'h00 : 8'($urandom);
      step(1, b, 1'($urandom));
      for (int g = $urandom_range(0, 3); g > 0; g--) step(0, 8'h00, 1'($urandom));
      checks++; if (pwm_width !== 24'(exp_width)) begin errors++; $display("FAIL rnd_width byte %0d got %0d exp %0d", i, pwm_width, exp_width); end
      checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_cnt byte %0d got %0d exp %0d", i, frame_cnt, exp_cnt); end
      checks++; if (ack_valid !== exp_ack_valid) begin errors++; $display("FAIL rnd_ack_valid byte %0d got %b exp %b", i, ack_valid, exp_ack_valid); end
      if (exp_ack_valid) begin
        checks++; if (ack_data !== exp_ack_data) begin errors++; $display("FAIL rnd_ack_data byte %0d got %h exp %h", i, ack_data, exp_ack_data); end
      end
      $display("random byte %0d data=%h width=%0d cnt=%0d ack=%b/%h", i, b, pwm_width, frame_cnt, ack_valid, ack_data);
    end
    // Pulse checks on the byte cycle itself, without trailing gaps.
    for (int i = 0; i < 200; i++) begin
      int r = $urandom_range(0, 99);
      logic [7:0] b = (r < 25) ? TERM : 8'($urandom);
      step(1, b, 1'($urandom));
      checks++; if (pwm_update !== exp_update) begin errors++; $display("FAIL rnd_update byte %0d got %b exp %b", i, pwm_update, exp_update); end
      checks++; if (frame_error !== exp_error) begin errors++; $display("FAIL rnd_error byte %0d got %b exp %b", i, frame_error, exp_error); end
      checks++; if (pwm_width !== 24'(exp_width)) begin errors++; $display("FAIL rnd2_width byte %0d got %0d exp %0d", i, pwm_width, exp_width); end
      $display("random2 byte %0d data=%h upd=%b err=%b", i, b, pwm_update, frame_error);
    end
  endtask

  task automatic test_wrap();
    step(1, TERM, 0);
    for (int n = 0; n < 300 && exp_cnt != 8'hFF; n++) begin
      step(1, 8'h00, 0); step(1, 8'h9E, 0); step(1, 8'h34, 0); step(1, TERM, 0);
    end
    checks++; if (frame_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_pre got %0d exp 255", frame_cnt); end
    step(1, 8'h00, 0); step(1, 8'hAB, 0); step(1, 8'hCD, 0); step(1, TERM, 0);
    checks++; if (frame_cnt !== 8'h00) begin errors++; $display("FAIL wrap_cnt got %0d exp 0", frame_cnt); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL wrap_error got %b exp 0", frame_error); end
    checks++; if (pwm_width !== 24'd43981) begin errors++; $display("FAIL wrap_width got %0d exp 43981", pwm_width); end
    $display("wrap: cnt=%0d width=%0d", frame_cnt, pwm_width);
  endtask

  task automatic test_midframe_reset();
    step(1, 8'h00, 0); step(1, 8'hD2, 0); step(1, 8'hF0, 0); step(1, TERM, 0);
    step(1, 8'h00, 1); step(1, 8'h9E, 1);
    reset_uart = 1'b1;
    #1;
    checks++; if (pwm_width !== 24'd40500) begin errors++; $display("FAIL mrst_width got %0d exp 40500", pwm_width); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL mrst_cnt got %0d exp 0", frame_cnt); end
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL mrst_ack_valid got %b exp 0", ack_valid); end
    checks++; if (ack_data !== 8'h00) begin errors++; $display("FAIL mrst_ack_data got %h exp 00", ack_data); end
    checks++; if (pwm_update !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL mrst_pulses got %b%b exp 00", pwm_update, frame_error); end
    model_reset();
    @(negedge clk);
    reset_uart = 1'b0;
    step(1, 8'h34, 0); step(1, TERM, 0);
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL mrst_partial_error got %b exp 1", frame_error); end
    checks++; if (ack_data !== NAK) begin errors++; $display("FAIL mrst_partial_nak got %h exp 15", ack_data); end
    checks++; if (pwm_width !== 24'(exp_width)) begin errors++; $display("FAIL mrst_partial_width got %0d exp %0d", pwm_width, exp_width); end
    $display("midframe reset: width=%0d err=%b ack=%h", pwm_width, frame_error, ack_data);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ack_hold();
    test_random();
    test_wrap();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
